// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the 2R1W register file
package regfile_pkg;

    localparam int RF_WIDTH_DEF = 8;
    localparam int RF_DEPTH_DEF = 8;

    // Replicated to any data width as {WIDTH{RF_ZERO_BIT}}
    localparam logic RF_ZERO_BIT = 1'b0;

    // DEPTH=2 still needs one address bit; larger depths round up to cover DEPTH-1
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/rf_read_mux.sv
// rtl/rf_read_mux.sv - DEPTH:1 combinational read selector, out-of-range selects zero
module rf_read_mux
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH_DEF,
    parameter int DEPTH = RF_DEPTH_DEF,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic [WIDTH*DEPTH-1:0] data_flat,
    input  logic [AW-1:0]          sel,
    output logic [WIDTH-1:0]       dout,
    output logic                   oor
);

    // A select that matches no register leaves dout at zero and flags oor
    always_comb begin
        dout = {WIDTH{RF_ZERO_BIT}};
        oor  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == AW'(i)) begin
                dout = data_flat[i*WIDTH +: WIDTH];
                oor  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w_sync.sv
// rtl/regfile_2r1w_sync.sv - register file, 1 write / 2 registered reads with write bypass
module regfile_2r1w_sync
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int AW       = addr_width(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re_a,
    input  logic [AW-1:0]    ra_a,
    output logic [WIDTH-1:0] rd_a,
    output logic             vld_a,
    input  logic             re_b,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] rd_b,
    output logic             vld_b,
    output logic             err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [WIDTH*DEPTH-1:0] mem_flat;
    logic [WIDTH-1:0]       mux_a, mux_b;
    logic [WIDTH-1:0]       nxt_a, nxt_b;
    logic                   oor_a, oor_b;
    logic                   wa_oor;
    logic                   wr_ok;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*WIDTH +: WIDTH] = mem[g];
    end

    rf_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mux_a (
        .data_flat (mem_flat),
        .sel       (ra_a),
        .dout      (mux_a),
        .oor       (oor_a)
    );

    rf_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mux_b (
        .data_flat (mem_flat),
        .sel       (ra_b),
        .dout      (mux_b),
        .oor       (oor_b)
    );

    assign wa_oor = ({1'b0, wa} >= DEPTH_W);
    assign wr_ok  = we && !wa_oor && !(ZERO_REG && (wa == '0));

    // Write-first bypass; hardwired zero and out-of-range reads override it
    always_comb begin
        nxt_a = mux_a;
        if (wr_ok && (wa == ra_a))
            nxt_a = wd;
        if (oor_a || (ZERO_REG && (ra_a == '0)))
            nxt_a = {WIDTH{RF_ZERO_BIT}};
    end

    always_comb begin
        nxt_b = mux_b;
        if (wr_ok && (wa == ra_b))
            nxt_b = wd;
        if (oor_b || (ZERO_REG && (ra_b == '0)))
            nxt_b = {WIDTH{RF_ZERO_BIT}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a  <= '0;
            rd_b  <= '0;
            vld_a <= 1'b0;
            vld_b <= 1'b0;
            err   <= 1'b0;
        end else begin
            vld_a <= re_a;
            vld_b <= re_b;
            if (re_a)
                rd_a <= nxt_a;
            if (re_b)
                rd_b <= nxt_b;
            if ((re_a && oor_a) || (re_b && oor_b) || (we && wa_oor))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_sync.sv
// tb/tb_regfile_2r1w_sync.sv - self-checking bench for regfile_2r1w_sync
module tb_regfile_2r1w_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0, re_a = 1'b0, re_b = 1'b0;
    logic [2:0] wa = '0, ra_a = '0, ra_b = '0;
    logic [7:0] wd = '0;

    logic [2:0][7:0] o_rd_a, o_rd_b;
    logic [2:0]      o_vld_a, o_vld_b, o_err;

    int checks = 0;
    int errors = 0;

    // Reference: dut0 = depth 8, dut1 = depth 8 with zero register, dut2 = depth 6
    int         m_depth [3] = '{8, 8, 6};
    bit         m_zr    [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_mem   [3][8];
    logic [7:0] m_rd_a  [3], m_rd_b [3];
    logic       m_vld_a [3], m_vld_b [3], m_err [3];

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       re_a;
        logic [2:0] ra_a;
        logic       re_b;
        logic [2:0] ra_b;
        logic [7:0] xa;
        logic       xva;
        logic [7:0] xb;
        logic       xvb;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    regfile_2r1w_sync #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .re_a(re_a), .ra_a(ra_a), .rd_a(o_rd_a[0]), .vld_a(o_vld_a[0]),
        .re_b(re_b), .ra_b(ra_b), .rd_b(o_rd_b[0]), .vld_b(o_vld_b[0]),
        .err(o_err[0])
    );

    regfile_2r1w_sync #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .re_a(re_a), .ra_a(ra_a), .rd_a(o_rd_a[1]), .vld_a(o_vld_a[1]),
        .re_b(re_b), .ra_b(ra_b), .rd_b(o_rd_b[1]), .vld_b(o_vld_b[1]),
        .err(o_err[1])
    );

    regfile_2r1w_sync #(.WIDTH(8), .DEPTH(6), .ZERO_REG(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .re_a(re_a), .ra_a(ra_a), .rd_a(o_rd_a[2]), .vld_a(o_vld_a[2]),
        .re_b(re_b), .ra_b(ra_b), .rd_b(o_rd_b[2]), .vld_b(o_vld_b[2]),
        .err(o_err[2])
    );

    task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
            m_rd_a[k] = 8'h00; m_rd_b[k] = 8'h00;
            m_vld_a[k] = 1'b0; m_vld_b[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    // Reads see the register contents after this edge's write has landed
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (we) begin
                if (int'(wa) >= m_depth[k]) m_err[k] = 1'b1;
                else if (!(m_zr[k] && wa == 3'd0)) m_mem[k][wa] = wd;
            end
            m_vld_a[k] = re_a;
            if (re_a) begin
                if (int'(ra_a) >= m_depth[k]) begin m_rd_a[k] = 8'h00; m_err[k] = 1'b1; end
                else m_rd_a[k] = m_mem[k][ra_a];
            end
            m_vld_b[k] = re_b;
            if (re_b) begin
                if (int'(ra_b) >= m_depth[k]) begin m_rd_b[k] = 8'h00; m_err[k] = 1'b1; end
                else m_rd_b[k] = m_mem[k][ra_b];
            end
        end
    endtask

    task automatic compare_model();
        for (int k = 0; k < 3; k++) begin
            check("model_rd_a", k, o_rd_a[k], m_rd_a[k]);
            check("model_vld_a", k, 8'(o_vld_a[k]), 8'(m_vld_a[k]));
            check("model_rd_b", k, o_rd_b[k], m_rd_b[k]);
            check("model_vld_b", k, 8'(o_vld_b[k]), 8'(m_vld_b[k]));
            check("model_err", k, 8'(o_err[k]), 8'(m_err[k]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle();
        we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    // Reset asserted mid-cycle must clear outputs without waiting for a clock edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_rd_a", k, o_rd_a[k], 8'h00);
            check("rst_vld_a", k, 8'(o_vld_a[k]), 8'h00);
            check("rst_rd_b", k, o_rd_b[k], 8'h00);
            check("rst_vld_b", k, 8'(o_vld_b[k]), 8'h00);
            check("rst_err", k, 8'(o_err[k]), 8'h00);
        end
        model_clear();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0, 8'hA5, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 8'hA5, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 3'd6, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0, 8'hA5, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 3'd6, 8'h7E, 1'b1, 3'd6, 1'b1, 3'd6, 8'h7E, 1'b1, 8'h7E, 1'b1};
        tbl[6] = '{1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 8'h7E, 1'b0, 8'h7E, 1'b0};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd0, 8'h7E, 1'b0, 8'hFF, 1'b1};
        tbl[8] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd6, 8'hA5, 1'b1, 8'h7E, 1'b1};
        tbl[9] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 3'd6, 8'h7E, 1'b1, 8'h7E, 1'b1};

        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        for (int v = 0; v < 10; v++) begin
            we = tbl[v].we; wa = tbl[v].wa; wd = tbl[v].wd;
            re_a = tbl[v].re_a; ra_a = tbl[v].ra_a;
            re_b = tbl[v].re_b; ra_b = tbl[v].ra_b;
            cycle();
            check($sformatf("vec%0d_rd_a", v), 0, o_rd_a[0], tbl[v].xa);
            check($sformatf("vec%0d_vld_a", v), 0, 8'(o_vld_a[0]), 8'(tbl[v].xva));
            check($sformatf("vec%0d_rd_b", v), 0, o_rd_b[0], tbl[v].xb);
            check($sformatf("vec%0d_vld_b", v), 0, 8'(o_vld_b[0]), 8'(tbl[v].xvb));
            if (v == 7) check("zero_reg_rd_b", 1, o_rd_b[1], 8'h00);
        end
        idle();

        // Out of range on the depth-6 instance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; wa = 3'(i); wd = 8'(8'h10 + i);
            cycle();
        end
        idle();
        re_a = 1'b1; ra_a = 3'd7;
        cycle();
        check("oor_rd_a", 2, o_rd_a[2], 8'h00);
        check("oor_vld_a", 2, 8'(o_vld_a[2]), 8'h01);
        check("oor_err", 2, 8'(o_err[2]), 8'h01);
        idle();
        we = 1'b1; wa = 3'd6; wd = 8'h33;
        cycle();
        idle();
        for (int i = 0; i < 6; i++) begin
            re_b = 1'b1; ra_b = 3'(i);
            cycle();
            check("oor_readback", 2, o_rd_b[2], 8'(8'h10 + i));
            check("oor_err_sticky", 2, 8'(o_err[2]), 8'h01);
        end
        idle();

        // Reset landing between request and clock edge discards the read
        we = 1'b1; wa = 3'd2; wd = 8'h5C;
        cycle();
        idle();
        re_a = 1'b1; ra_a = 3'd2;
        do_reset();
        cycle();
        check("midrst_rd_a", 0, o_rd_a[0], 8'h00);
        check("midrst_vld_a", 0, 8'(o_vld_a[0]), 8'h01);
        idle();

        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom); wa = 3'($urandom_range(0, 7)); wd = 8'($urandom);
            re_a = 1'($urandom); ra_a = 3'($urandom_range(0, 7));
            re_b = 1'($urandom); ra_b = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            if (n == 200) begin
                idle();
                do_reset();
            end
            cycle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sync.md
Name: regfile_2r1w_sync

Overview:
- Parametrised register file: DEPTH registers of WIDTH bits, one synchronous write port and two independently enabled read ports.
- Read data is registered, with write-to-read bypass.
- Replaces the free-standing 8:1 read-select mux plus separate register storage in the register-file datapath.
- Feeds operand buses of downstream ALU/datapath blocks.

Parameters:
- WIDTH, 8, data width of each register in bits.
- DEPTH, 8, number of registers; any value 2..256, not required to be a power of two.
- AW, $clog2(DEPTH), address width (derived; not overridden by instantiators).
- ZERO_REG, 0, when 1 register 0 is hardwired: reads return 0 and writes to address 0 are dropped.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- wa  input  AW  write address.
- wd  input  WIDTH  write data.
- re_a  input  1  read enable, port A.
- ra_a  input  AW  read address, port A.
- rd_a  output  WIDTH  registered read data, port A.
- vld_a  output  1  rd_a updated this cycle.
- re_b  input  1  read enable, port B.
- ra_b  input  AW  read address, port B.
- rd_b  output  WIDTH  registered read data, port B.
- vld_b  output  1  rd_b updated this cycle.
- err  output  1  sticky out-of-range access flag.

Behaviour:
- Reset (rst_n low, asynchronous): all DEPTH registers cleared to 0. rd_a, rd_b = 0; vld_a, vld_b = 0; err = 0. Values hold until the first rising clk edge after rst_n deasserts.
- Write: at rising clk with we=1 and wa<DEPTH, mem[wa] <= wd. Dropped if ZERO_REG=1 and wa=0.
- Read, 1-cycle latency: at a rising clk edge with re_x=1:
  - rd_x <= value of ra_x as seen after any same-edge write (bypass). If we=1 and wa==ra_x and the write is not dropped, rd_x <= wd; else rd_x <= mem[ra_x].
  - vld_x <= 1.
- With re_x=0: rd_x holds its previous value; vld_x <= 0.
- Zero register: with ZERO_REG=1 and ra_x=0, rd_x <= 0 regardless of bypass.
- Out of range (ra_x>=DEPTH or wa>=DEPTH with the enable set):
  - Reads return 0 with vld_x=1.
  - Writes are ignored.
  - err <= 1 and stays 1 until reset.
- Simultaneous events:
  - Ports A and B may read the same address in the same cycle; both get identical data.
  - Read and write of the same address in one cycle returns the new data (write-first).
- Reset mid-operation: in-flight reads are discarded; vld_x falls immediately with rst_n.
- No state machine. State is the register array, two output registers, two valid flops and the err flop.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH/DEPTH constants
  - function addr_width(depth)
  - localparam for the zero value
- Sub-module rf_read_mux: parametrised DEPTH:1 combinational selector with inputs WIDTH*DEPTH flat bus, select, and out-of-range-returns-zero. It generalises the existing 8:1 mux and is instantiated once per read port.
- Bypass compare and output flops stay in the top module.

Test Plan (WIDTH=8, DEPTH=8, ZERO_REG=0 unless stated):
1. Reset then read: assert rst_n=0 mid-cycle → rd_a=rd_b=0, vld=0 immediately. Release, then re_a=1, ra_a=5 → next cycle rd_a=0x00, vld_a=1.
2. Write then read: we=1, wa=3, wd=0xA5 at cycle n; re_a=1, ra_a=3 at n+1 → rd_a=0xA5 at n+2, vld_a=1. With re_a=0 at n+2, rd_a holds 0xA5 and vld_a=0 at n+3.
3. Bypass and dual read: mem[6]=0x11. In one cycle drive we=1, wa=6, wd=0x7E, re_a=re_b=1, ra_a=ra_b=6 → next cycle rd_a=rd_b=0x7E.
4. Zero register: ZERO_REG=1, write 0xFF to wa=0, then read ra_b=0 → rd_b=0x00. Same bench with ZERO_REG=0 → rd_b=0xFF.
5. Out of range: DEPTH=6, read ra_a=7 → rd_a=0, vld_a=1, err=1. Write wa=6, wd=0x33 → no register changes (full readback of 0..5 unchanged), err remains 1 until rst_n pulse.
6. Reset mid-read: re_a=1, ra_a=2 with mem[2]=0x5C; pulse rst_n low before the clock edge → rd_a=0, vld_a=0, mem[2] reads back 0x00 after release.
